// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter sharing one single-port RAM (sync write, combinational read).
// Define RAM_ARB_FIXED_PRI_EN for fixed priority (requester 0 wins); default is round-robin with burst limit.
module ram_port_arbiter #(
  parameter int ADDRESS_SIZE = 10,
  parameter int DATA_SIZE    = 10,
  parameter int MAX_BURST    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0,
  input  logic                    we0,
  input  logic [ADDRESS_SIZE-1:0] addr0,
  input  logic [DATA_SIZE-1:0]    wdata0,
  output logic                    gnt0,
  output logic [DATA_SIZE-1:0]    rdata0,
  output logic                    rvalid0,
  input  logic                    req1,
  input  logic                    we1,
  input  logic [ADDRESS_SIZE-1:0] addr1,
  input  logic [DATA_SIZE-1:0]    wdata1,
  output logic                    gnt1,
  output logic [DATA_SIZE-1:0]    rdata1,
  output logic                    rvalid1,
  output logic [ADDRESS_SIZE-1:0] ram_address,
  output logic [DATA_SIZE-1:0]    ram_data_in,
  output logic                    ram_write,
  output logic                    ram_chip_select,
  input  logic [DATA_SIZE-1:0]    ram_data_out
);

  logic                    w_gnt0;
  logic                    w_gnt1;
  logic                    w_acc;
  logic                    r_ram_cs;
  logic                    r_ram_we;
  logic                    r_ram_sel;
  logic [ADDRESS_SIZE-1:0] r_ram_addr;
  logic [DATA_SIZE-1:0]    r_ram_din;
  logic [DATA_SIZE-1:0]    r_rdata0;
  logic [DATA_SIZE-1:0]    r_rdata1;
  logic                    r_rvalid0;
  logic                    r_rvalid1;

`ifdef RAM_ARB_FIXED_PRI_EN
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!rst) begin
      w_gnt0 = req0;
      w_gnt1 = req1 && !req0;
    end
  end
`else
  localparam logic [3:0] LP_MAX_BURST = 4'(MAX_BURST);

  // r_owner0=1 means requester 0 owns the current burst, so reset value 1 favours requester 0.
  logic       r_owner0;
  logic [3:0] r_count;
  logic       w_owner_wins;

  always_comb begin
    w_gnt0       = 1'b0;
    w_gnt1       = 1'b0;
    w_owner_wins = (r_count < LP_MAX_BURST);
    if (!rst) begin
      if (req0 && req1) begin
        w_gnt0 = w_owner_wins ? r_owner0 : !r_owner0;
        w_gnt1 = !w_gnt0;
      end else begin
        w_gnt0 = req0;
        w_gnt1 = req1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner0 <= 1'b1;
      r_count  <= '0;
    end else if (w_gnt0 || w_gnt1) begin
      if (w_gnt0 == r_owner0) begin
        if (r_count != 4'hF) r_count <= r_count + 4'd1;
      end else begin
        r_owner0 <= w_gnt0;
        r_count  <= 4'd1;
      end
    end else begin
      r_count <= '0;
    end
  end
`endif

  assign w_acc = w_gnt0 || w_gnt1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ram_cs   <= 1'b0;
      r_ram_we   <= 1'b0;
      r_ram_sel  <= 1'b0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
    end else begin
      r_ram_cs <= w_acc;
      r_ram_we <= w_acc && (w_gnt1 ? we1 : we0);
      if (w_acc) begin
        r_ram_sel  <= w_gnt1;
        r_ram_addr <= w_gnt1 ? addr1 : addr0;
        r_ram_din  <= w_gnt1 ? wdata1 : wdata0;
      end
    end
  end

  // Read data is captured at the end of the cycle the read is driven on the RAM port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata0  <= '0;
      r_rdata1  <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= r_ram_cs && !r_ram_we && !r_ram_sel;
      r_rvalid1 <= r_ram_cs && !r_ram_we && r_ram_sel;
      if (r_ram_cs && !r_ram_we && !r_ram_sel) r_rdata0 <= ram_data_out;
      if (r_ram_cs && !r_ram_we && r_ram_sel)  r_rdata1 <= ram_data_out;
    end
  end

  assign gnt0            = w_gnt0;
  assign gnt1            = w_gnt1;
  assign rdata0          = r_rdata0;
  assign rdata1          = r_rdata1;
  assign rvalid0         = r_rvalid0;
  assign rvalid1         = r_rvalid1;
  assign ram_address     = r_ram_addr;
  assign ram_data_in     = r_ram_din;
  assign ram_write       = r_ram_we;
  assign ram_chip_select = r_ram_cs;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter with a behavioural RAM attached to the RAM port.
module tb_ram_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data_in, ram_data_out;
  logic          ram_write, ram_chip_select;
  logic          mem_init = 1'b1;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_cmp = 0;
  int n_err = 0;

  ram_port_arbiter #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rdata0(rdata0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rdata1(rdata1), .rvalid1(rvalid1),
    .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_write(ram_write), .ram_chip_select(ram_chip_select),
    .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  // RAM contents after init: mem[a] = 3*a+1.
  assign ram_data_out = mem[ram_address];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < (1<<AW); i++) mem[i] <= DW'(i*3+1);
    end else if (ram_chip_select && ram_write) begin
      mem[ram_address] <= ram_data_in;
    end
  end

  always begin
    @(negedge clk);
    #3;
    n_cmp++;
    if ((gnt0 && gnt1) || (ram_write && !ram_chip_select)) begin
      n_err++;
      $display("FAIL exclusive: gnt0=%b gnt1=%b ram_write=%b cs=%b, required no double grant and no write without cs",
               gnt0, gnt1, ram_write, ram_chip_select);
    end
  end

  task automatic test_reset();
    rst = 1'b1; mem_init = 1'b1;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1; addr0 = 10'd5; addr1 = 10'd6;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if ({gnt0, gnt1} !== 2'b00) begin n_err++; $display("FAIL reset_gnt: got %b expected 00", {gnt0, gnt1}); end
    n_cmp++; if ({ram_chip_select, ram_write} !== 2'b00) begin n_err++; $display("FAIL reset_ram_ctl: got %b expected 00", {ram_chip_select, ram_write}); end
    n_cmp++; if ({ram_address, ram_data_in} !== 20'h0) begin n_err++; $display("FAIL reset_ram_bus: got %h expected 0", {ram_address, ram_data_in}); end
    n_cmp++; if ({rvalid0, rvalid1} !== 2'b00) begin n_err++; $display("FAIL reset_rvalid: got %b expected 00", {rvalid0, rvalid1}); end
    n_cmp++; if ({rdata0, rdata1} !== 20'h0) begin n_err++; $display("FAIL reset_rdata: got %h expected 0", {rdata0, rdata1}); end
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; mem_init = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    @(negedge clk); req0 = 1'b1; we0 = 1'b1; addr0 = 10'd5; wdata0 = 10'h02A; #1;
    n_cmp++; if ({gnt0, gnt1} !== 2'b10) begin n_err++; $display("FAIL wr_gnt: got %b expected 10", {gnt0, gnt1}); end
    @(negedge clk); we0 = 1'b0; wdata0 = '0; #1;
    n_cmp++; if ({ram_chip_select, ram_write, ram_address, ram_data_in} !== {1'b1, 1'b1, 10'd5, 10'h02A}) begin
      n_err++; $display("FAIL wr_drive: got %h expected %h", {ram_chip_select, ram_write, ram_address, ram_data_in}, {1'b1, 1'b1, 10'd5, 10'h02A});
    end
    n_cmp++; if ({gnt0, gnt1} !== 2'b10) begin n_err++; $display("FAIL rd_gnt: got %b expected 10", {gnt0, gnt1}); end
    @(negedge clk); req0 = 1'b0; #1;
    n_cmp++; if ({ram_chip_select, ram_write, ram_address} !== {1'b1, 1'b0, 10'd5}) begin
      n_err++; $display("FAIL rd_drive: got %h expected %h", {ram_chip_select, ram_write, ram_address}, {1'b1, 1'b0, 10'd5});
    end
    n_cmp++; if ({rvalid0, rvalid1} !== 2'b00) begin n_err++; $display("FAIL wr_no_rvalid: got %b expected 00", {rvalid0, rvalid1}); end
    @(negedge clk); #1;
    n_cmp++; if ({rvalid0, rvalid1, rdata0} !== {1'b1, 1'b0, 10'h02A}) begin
      n_err++; $display("FAIL rd_return: got %h expected %h", {rvalid0, rvalid1, rdata0}, {1'b1, 1'b0, 10'h02A});
    end
    @(negedge clk); #1;
    n_cmp++; if ({rvalid0, rdata0} !== {1'b0, 10'h02A}) begin
      n_err++; $display("FAIL rd_hold: got %h expected %h", {rvalid0, rdata0}, {1'b0, 10'h02A});
    end
  endtask

  task automatic test_round_robin();
    int         exp_g [12];
    logic [1:0] eg;
    logic [1:0] ev;
`ifdef RAM_ARB_FIXED_PRI_EN
    exp_g = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2};
`else
    exp_g = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 2, 2};
`endif
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      req0 = (k < 10); req1 = (k < 10); we0 = 1'b0; we1 = 1'b0; addr0 = 10'd10; addr1 = 10'd20;
      #1;
      eg = (exp_g[k] == 0) ? 2'b10 : (exp_g[k] == 1) ? 2'b01 : 2'b00;
      n_cmp++; if ({gnt0, gnt1} !== eg) begin n_err++; $display("FAIL rr_gnt[%0d]: got %b expected %b", k, {gnt0, gnt1}, eg); end
      if (k >= 2) begin
        ev = (exp_g[k-2] == 0) ? 2'b10 : (exp_g[k-2] == 1) ? 2'b01 : 2'b00;
        n_cmp++; if ({rvalid0, rvalid1} !== ev) begin n_err++; $display("FAIL rr_rvalid[%0d]: got %b expected %b", k, {rvalid0, rvalid1}, ev); end
        if (ev == 2'b10) begin
          n_cmp++; if (rdata0 !== 10'd31) begin n_err++; $display("FAIL rr_rdata0[%0d]: got %0d expected 31", k, rdata0); end
        end else if (ev == 2'b01) begin
          n_cmp++; if (rdata1 !== 10'd61) begin n_err++; $display("FAIL rr_rdata1[%0d]: got %0d expected 61", k, rdata1); end
        end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_raw_cross();
    @(negedge clk); req0 = 1'b0; req1 = 1'b1; we1 = 1'b1; addr1 = 10'd3; wdata1 = 10'h011; #1;
    n_cmp++; if ({gnt0, gnt1} !== 2'b01) begin n_err++; $display("FAIL raw_wr_gnt: got %b expected 01", {gnt0, gnt1}); end
    @(negedge clk); req1 = 1'b0; we1 = 1'b0; req0 = 1'b1; we0 = 1'b0; addr0 = 10'd3; #1;
    n_cmp++; if ({gnt0, gnt1} !== 2'b10) begin n_err++; $display("FAIL raw_rd_gnt: got %b expected 10", {gnt0, gnt1}); end
    n_cmp++; if ({ram_chip_select, ram_write, ram_address, ram_data_in} !== {1'b1, 1'b1, 10'd3, 10'h011}) begin
      n_err++; $display("FAIL raw_wr_drive: got %h expected %h", {ram_chip_select, ram_write, ram_address, ram_data_in}, {1'b1, 1'b1, 10'd3, 10'h011});
    end
    @(negedge clk); req0 = 1'b0; #1;
    n_cmp++; if ({ram_chip_select, ram_write, ram_address} !== {1'b1, 1'b0, 10'd3}) begin
      n_err++; $display("FAIL raw_rd_drive: got %h expected %h", {ram_chip_select, ram_write, ram_address}, {1'b1, 1'b0, 10'd3});
    end
    @(negedge clk); #1;
    n_cmp++; if ({rvalid0, rvalid1, rdata0} !== {1'b1, 1'b0, 10'h011}) begin
      n_err++; $display("FAIL raw_return: got %h expected %h", {rvalid0, rvalid1, rdata0}, {1'b1, 1'b0, 10'h011});
    end
  endtask

  task automatic test_back_to_back();
    // Addresses 3 and 5 were overwritten by earlier scenarios.
    logic [DW-1:0] exp_d [8] = '{10'd1, 10'd4, 10'd7, 10'h011, 10'd13, 10'h02A, 10'd19, 10'd22};
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      req1 = (k < 8); we1 = 1'b0; addr1 = (k < 8) ? AW'(k) : '0;
      #1;
      n_cmp++; if ({gnt0, gnt1} !== ((k < 8) ? 2'b01 : 2'b00)) begin
        n_err++; $display("FAIL b2b_gnt[%0d]: got %b expected %b", k, {gnt0, gnt1}, (k < 8) ? 2'b01 : 2'b00);
      end
      if (k >= 2 && k < 10) begin
        n_cmp++; if ({rvalid0, rvalid1, rdata1} !== {1'b0, 1'b1, exp_d[k-2]}) begin
          n_err++; $display("FAIL b2b_rdata[%0d]: got %h expected %h", k, {rvalid0, rvalid1, rdata1}, {1'b0, 1'b1, exp_d[k-2]});
        end
      end else begin
        n_cmp++; if ({rvalid0, rvalid1} !== 2'b00) begin n_err++; $display("FAIL b2b_quiet[%0d]: got %b expected 00", k, {rvalid0, rvalid1}); end
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); req0 = 1'b1; we0 = 1'b1; addr0 = 10'd7; wdata0 = 10'h3FF; #1;
    n_cmp++; if ({gnt0, gnt1} !== 2'b10) begin n_err++; $display("FAIL rm_gnt: got %b expected 10", {gnt0, gnt1}); end
    @(negedge clk); req0 = 1'b0; we0 = 1'b0; #1;
    n_cmp++; if ({ram_chip_select, ram_write, ram_address} !== {1'b1, 1'b1, 10'd7}) begin
      n_err++; $display("FAIL rm_drive: got %h expected %h", {ram_chip_select, ram_write, ram_address}, {1'b1, 1'b1, 10'd7});
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if ({ram_chip_select, ram_write} !== 2'b00) begin n_err++; $display("FAIL rm_drop: got %b expected 00", {ram_chip_select, ram_write}); end
    n_cmp++; if ({rdata0, rdata1} !== 20'h0) begin n_err++; $display("FAIL rm_rdata_clr: got %h expected 0", {rdata0, rdata1}); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); req0 = 1'b1; we0 = 1'b0; addr0 = 10'd7; #1;
    n_cmp++; if ({gnt0, gnt1, rvalid0, rvalid1} !== 4'b1000) begin
      n_err++; $display("FAIL rm_rd_gnt: got %b expected 1000", {gnt0, gnt1, rvalid0, rvalid1});
    end
    @(negedge clk); req0 = 1'b0; #1;
    n_cmp++; if ({ram_chip_select, ram_write, ram_address, rvalid0} !== {1'b1, 1'b0, 10'd7, 1'b0}) begin
      n_err++; $display("FAIL rm_rd_drive: got %h expected %h", {ram_chip_select, ram_write, ram_address, rvalid0}, {1'b1, 1'b0, 10'd7, 1'b0});
    end
    @(negedge clk); #1;
    n_cmp++; if ({rvalid0, rdata0} !== {1'b1, 10'd22}) begin
      n_err++; $display("FAIL rm_prior_data: got %h expected %h", {rvalid0, rdata0}, {1'b1, 10'd22});
    end
  endtask

  task automatic test_idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); req0 = 1'b0; req1 = 1'b0; #1;
      n_cmp++; if ({gnt0, gnt1, ram_chip_select, ram_write, rvalid0, rvalid1} !== 6'b000000) begin
        n_err++; $display("FAIL idle_ctl[%0d]: got %b expected 000000", k, {gnt0, gnt1, ram_chip_select, ram_write, rvalid0, rvalid1});
      end
      n_cmp++; if ({ram_address, rdata0} !== {10'd7, 10'd22}) begin
        n_err++; $display("FAIL idle_hold[%0d]: got %h expected %h", k, {ram_address, rdata0}, {10'd7, 10'd22});
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_round_robin();
    test_raw_cross();
    test_back_to_back();
    test_reset_mid();
    test_idle();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
